decode_pipeline: RTL and testbench

DECODE_PIPELINE -- requirements
Module: decode_pipeline

---
 rtl/decode_pipeline_if.sv | 38 +++
 rtl/decode_pipeline.sv | 214 +++++++++++++++++++++
 tb/tb_decode_pipeline.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/decode_pipeline_if.sv
// Bundle between fetch/writeback and the decode stage, plus the registered D/E outputs.
// The master drives D-stage and writeback inputs; the slave (decode) drives the E-stage outputs.
interface decode_pipeline_if;
    logic [31:0] Instr_D;
    logic [31:0] PC_D;
    logic [31:0] PCPlusD;
    logic        RegWrite_W;
    logic [4:0]  RD_W;
    logic [31:0] Result_W;
    logic        Flush_E;

    logic        RegWrite_E;
    logic        MemWrite_E;
    logic        Branch_E;
    logic        ALUSrc_E;
    logic        ResultSrc_E;
    logic [2:0]  ALUControl_E;
    logic [31:0] RD1_E;
    logic [31:0] RD2_E;
    logic [31:0] Imm_Ext_E;
    logic [31:0] PC_E;
    logic [31:0] PCPlusE;
    logic [4:0]  RS1_E;
    logic [4:0]  RS2_E;
    logic [4:0]  RD_E;

    modport master (
        output Instr_D, PC_D, PCPlusD, RegWrite_W, RD_W, Result_W, Flush_E,
        input  RegWrite_E, MemWrite_E, Branch_E, ALUSrc_E, ResultSrc_E, ALUControl_E,
        input  RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlusE, RS1_E, RS2_E, RD_E
    );

    modport slave (
        input  Instr_D, PC_D, PCPlusD, RegWrite_W, RD_W, Result_W, Flush_E,
        output RegWrite_E, MemWrite_E, Branch_E, ALUSrc_E, ResultSrc_E, ALUControl_E,
        output RD1_E, RD2_E, Imm_Ext_E, PC_E, PCPlusE, RS1_E, RS2_E, RD_E
    );
endinterface

// File: rtl/decode_pipeline.sv
// RV32 subset decode stage: register file with write-read bypass, control/immediate decode,
// and the D/E pipeline register with flush.
module decode_pipeline (
    input  logic            clk,
    input  logic            rst,
    decode_pipeline_if.slave io_bus
);
    typedef enum logic [1:0] {ImmNone, ImmI, ImmS, ImmB} imm_src_e;

    logic [31:0] r_regs [32];

    logic [31:0] w_instr;
    logic [6:0]  w_op;
    logic [2:0]  w_f3;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_wr_en;
    logic [31:0] w_rd1;
    logic [31:0] w_rd2;

    logic        w_regwrite;
    logic        w_alusrc;
    logic        w_memwrite;
    logic        w_resultsrc;
    logic        w_branch;
    logic [1:0]  w_aluop;
    imm_src_e    w_immsrc;
    logic [2:0]  w_aluctrl;
    logic [31:0] w_imm;

    assign w_instr = io_bus.Instr_D;
    assign w_op    = w_instr[6:0];
    assign w_f3    = w_instr[14:12];
    assign w_rs1   = w_instr[19:15];
    assign w_rs2   = w_instr[24:20];
    assign w_rd    = w_instr[11:7];
    assign w_wr_en = io_bus.RegWrite_W && (io_bus.RD_W != 5'd0);

    // Flush does not gate the write: writeback belongs to an older instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[io_bus.RD_W] <= io_bus.Result_W;
        end
    end

    always_comb begin
        if (w_rs1 == 5'd0) begin
            w_rd1 = '0;
        end else if (w_wr_en && (io_bus.RD_W == w_rs1)) begin
            w_rd1 = io_bus.Result_W;
        end else begin
            w_rd1 = r_regs[w_rs1];
        end
        if (w_rs2 == 5'd0) begin
            w_rd2 = '0;
        end else if (w_wr_en && (io_bus.RD_W == w_rs2)) begin
            w_rd2 = io_bus.Result_W;
        end else begin
            w_rd2 = r_regs[w_rs2];
        end
    end

    always_comb begin
        w_regwrite  = 1'b0;
        w_alusrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_resultsrc = 1'b0;
        w_branch    = 1'b0;
        w_aluop     = 2'b00;
        w_immsrc    = ImmNone;
        case (w_op)
            7'b0000011: begin
                w_regwrite  = 1'b1;
                w_alusrc    = 1'b1;
                w_resultsrc = 1'b1;
                w_immsrc    = ImmI;
            end
            7'b0100011: begin
                w_alusrc   = 1'b1;
                w_memwrite = 1'b1;
                w_immsrc   = ImmS;
            end
            7'b0110011: begin
                w_regwrite = 1'b1;
                w_aluop    = 2'b10;
            end
            7'b0010011: begin
                w_regwrite = 1'b1;
                w_alusrc   = 1'b1;
                w_aluop    = 2'b10;
                w_immsrc   = ImmI;
            end
            7'b1100011: begin
                w_branch = 1'b1;
                w_aluop  = 2'b01;
                w_immsrc = ImmB;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_aluctrl = 3'b000;
        case (w_aluop)
            2'b01: w_aluctrl = 3'b001;
            2'b10: begin
                case (w_f3)
                    // Only R-type (op[5]=1) with funct7[5] is a subtract; addi never is.
                    3'b000:  w_aluctrl = (w_instr[5] && w_instr[30]) ? 3'b001 : 3'b000;
                    3'b010:  w_aluctrl = 3'b101;
                    3'b110:  w_aluctrl = 3'b011;
                    3'b111:  w_aluctrl = 3'b010;
                    default: w_aluctrl = 3'b000;
                endcase
            end
            default: w_aluctrl = 3'b000;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_immsrc)
            ImmI:    w_imm = {{20{w_instr[31]}}, w_instr[31:20]};
            ImmS:    w_imm = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
            ImmB:    w_imm = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                              w_instr[11:8], 1'b0};
            default: w_imm = '0;
        endcase
    end

    logic        r_regwrite;
    logic        r_memwrite;
    logic        r_branch;
    logic        r_alusrc;
    logic        r_resultsrc;
    logic [2:0]  r_aluctrl;
    logic [31:0] r_rd1;
    logic [31:0] r_rd2;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic [31:0] r_pcplus;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_branch    <= 1'b0;
            r_alusrc    <= 1'b0;
            r_resultsrc <= 1'b0;
            r_aluctrl   <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pcplus    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else if (io_bus.Flush_E) begin
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_branch    <= 1'b0;
            r_alusrc    <= 1'b0;
            r_resultsrc <= 1'b0;
            r_aluctrl   <= '0;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_imm       <= '0;
            r_pc        <= '0;
            r_pcplus    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
        end else begin
            r_regwrite  <= w_regwrite;
            r_memwrite  <= w_memwrite;
            r_branch    <= w_branch;
            r_alusrc    <= w_alusrc;
            r_resultsrc <= w_resultsrc;
            r_aluctrl   <= w_aluctrl;
            r_rd1       <= w_rd1;
            r_rd2       <= w_rd2;
            r_imm       <= w_imm;
            r_pc        <= io_bus.PC_D;
            r_pcplus    <= io_bus.PCPlusD;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
        end
    end

    assign io_bus.RegWrite_E   = r_regwrite;
    assign io_bus.MemWrite_E   = r_memwrite;
    assign io_bus.Branch_E     = r_branch;
    assign io_bus.ALUSrc_E     = r_alusrc;
    assign io_bus.ResultSrc_E  = r_resultsrc;
    assign io_bus.ALUControl_E = r_aluctrl;
    assign io_bus.RD1_E        = r_rd1;
    assign io_bus.RD2_E        = r_rd2;
    assign io_bus.Imm_Ext_E    = r_imm;
    assign io_bus.PC_E         = r_pc;
    assign io_bus.PCPlusE      = r_pcplus;
    assign io_bus.RS1_E        = r_rs1;
    assign io_bus.RS2_E        = r_rs2;
    assign io_bus.RD_E         = r_rd;
endmodule

// File: tb/tb_decode_pipeline.sv
// Scoreboard bench for decode_pipeline: expected E-stage values are queued as each
// instruction is driven and compared one cycle later.
module tb_decode_pipeline;
    typedef struct packed {
        logic        regw;
        logic        memw;
        logic        br;
        logic        alusrc;
        logic        ressrc;
        logic [2:0]  aluc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } e_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    e_t   q[$];

    decode_pipeline_if bus ();

    decode_pipeline u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    function automatic e_t sample();
        e_t s;
        s.regw   = bus.RegWrite_E;
        s.memw   = bus.MemWrite_E;
        s.br     = bus.Branch_E;
        s.alusrc = bus.ALUSrc_E;
        s.ressrc = bus.ResultSrc_E;
        s.aluc   = bus.ALUControl_E;
        s.rd1    = bus.RD1_E;
        s.rd2    = bus.RD2_E;
        s.imm    = bus.Imm_Ext_E;
        s.pc     = bus.PC_E;
        s.pcp    = bus.PCPlusE;
        s.rs1    = bus.RS1_E;
        s.rs2    = bus.RS2_E;
        s.rd     = bus.RD_E;
        return s;
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] pcp,
                         input logic rw, input logic [4:0] rdw, input logic [31:0] res,
                         input logic flush);
        bus.Instr_D    = instr;
        bus.PC_D       = pc;
        bus.PCPlusD    = pcp;
        bus.RegWrite_W = rw;
        bus.RD_W       = rdw;
        bus.Result_W   = res;
        bus.Flush_E    = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        e_t exp, got;
        drive(32'h0070_0293, 32'd4, 32'd5, 1'b1, 5'd3, 32'h1234, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            got = sample();
            checks++;
            if (got !== '0) begin
                failures++;
                $display("FAIL reset_hold got=%h exp=0", got);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        // add x1,x3,x0: x3 write during reset must not have landed
        drive(32'h0001_80B3, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.rs1 = 5'd3; exp.rd = 5'd1;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_no_write got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_random_imm();
        e_t exp, got;
        logic [11:0] imm;
        for (int i = 0; i < 16; i++) begin
            imm = 12'($urandom);
            exp = '0;
            exp.alusrc = 1'b1;
            exp.imm = {{20{imm[11]}}, imm};
            if (i[0]) begin
                drive({imm[11:5], 5'd0, 5'd0, 3'b010, imm[4:0], 7'b0100011},
                      32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
                exp.memw = 1'b1;
                exp.rd = imm[4:0];
            end else begin
                drive({imm, 5'd0, 3'b000, 5'd1, 7'b0010011}, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
                exp.regw = 1'b1;
                exp.rs2 = imm[4:0];
                exp.rd = 5'd1;
            end
            q.push_back(exp);
            tick();
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL random_imm[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_addi();
        e_t exp, got;
        drive(32'h0070_0293, 32'd4, 32'd5, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.alusrc = 1'b1; exp.imm = 32'd7;
        exp.pc = 32'd4; exp.pcp = 32'd5; exp.rs2 = 5'd7; exp.rd = 5'd5;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL addi got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_load_bypass();
        e_t exp, got;
        drive(32'h0082_A303, 32'd8, 32'd9, 1'b1, 5'd5, 32'h2A, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.alusrc = 1'b1; exp.ressrc = 1'b1;
        exp.rd1 = 32'h2A; exp.imm = 32'd8; exp.pc = 32'd8; exp.pcp = 32'd9;
        exp.rs1 = 5'd5; exp.rs2 = 5'd8; exp.rd = 5'd6;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL lw_bypass got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_store();
        e_t exp, got;
        // Fetch bubble while writing x6
        drive(32'h0000_0000, 32'd0, 32'd0, 1'b1, 5'd6, 32'h55, 1'b0);
        q.push_back('0);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL bubble_zero got=%h exp=%h", got, exp);
        end
        drive(32'h0062_A223, 32'd12, 32'd13, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.memw = 1'b1; exp.alusrc = 1'b1; exp.rd1 = 32'h2A; exp.rd2 = 32'h55;
        exp.imm = 32'd4; exp.pc = 32'd12; exp.pcp = 32'd13;
        exp.rs1 = 5'd5; exp.rs2 = 5'd6; exp.rd = 5'd4;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL sw got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_sub_flush();
        e_t exp, got;
        drive(32'h4053_03B3, 32'd16, 32'd17, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.aluc = 3'b001; exp.rd1 = 32'h55; exp.rd2 = 32'h2A;
        exp.pc = 32'd16; exp.pcp = 32'd17; exp.rs1 = 5'd6; exp.rs2 = 5'd5; exp.rd = 5'd7;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL sub got=%h exp=%h", got, exp);
        end
        // Flush with a concurrent writeback to x7
        drive(32'h4053_03B3, 32'd16, 32'd17, 1'b1, 5'd7, 32'h99, 1'b1);
        q.push_back('0);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush got=%h exp=%h", got, exp);
        end
        drive(32'h0003_8413, 32'd20, 32'd21, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.alusrc = 1'b1; exp.rd1 = 32'h99;
        exp.pc = 32'd20; exp.pcp = 32'd21; exp.rs1 = 5'd7; exp.rd = 5'd8;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL flush_write got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_branch();
        e_t exp, got;
        drive(32'hFE62_8EE3, 32'd24, 32'd25, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.br = 1'b1; exp.aluc = 3'b001; exp.rd1 = 32'h2A; exp.rd2 = 32'h55;
        exp.imm = 32'hFFFF_FFFC; exp.pc = 32'd24; exp.pcp = 32'd25;
        exp.rs1 = 5'd5; exp.rs2 = 5'd6; exp.rd = 5'd29;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL beq got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_alu_funct();
        e_t exp, got;
        logic [6:0] ops [6];
        logic [2:0] f3s [6];
        logic [2:0] acs [6];
        ops = '{7'b0110011, 7'b0110011, 7'b0110011, 7'b0110011, 7'b0010011, 7'b1101111};
        f3s = '{3'b010, 3'b110, 3'b111, 3'b100, 3'b000, 3'b000};
        acs = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b000};
        for (int i = 0; i < 6; i++) begin
            // funct7 = 0100000 on the I-ALU entry: must stay add, not sub
            drive({(i == 4) ? 7'b0100000 : 7'b0, 5'd0, 5'd0, f3s[i], 5'd2, ops[i]},
                  32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
            exp = '0; exp.rd = 5'd2; exp.aluc = acs[i];
            if (i < 5) exp.regw = 1'b1;
            if (i == 4) begin
                exp.alusrc = 1'b1;
                exp.imm = 32'h400;
            end
            q.push_back(exp);
            tick();
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL alu_funct[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_x0();
        e_t exp, got;
        for (int i = 0; i < 2; i++) begin
            drive(32'h0000_00B3, 32'd0, 32'd0, (i == 0), 5'd0, 32'hFFFF_FFFF, 1'b0);
            exp = '0; exp.regw = 1'b1; exp.rd = 5'd1;
            q.push_back(exp);
            tick();
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL x0_read[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        e_t exp, got;
        for (int i = 1; i <= 6; i++) begin
            drive({7'b0, 5'(9 + i), 5'(10 + i), 3'b000, 5'd20, 7'b0110011},
                  32'(i), 32'(i + 1), 1'b1, 5'(10 + i), 32'(i * 32'h111), 1'b0);
            exp = '0; exp.regw = 1'b1; exp.rd1 = 32'(i * 32'h111);
            exp.rd2 = 32'((i - 1) * 32'h111); exp.pc = 32'(i); exp.pcp = 32'(i + 1);
            exp.rs1 = 5'(10 + i); exp.rs2 = 5'(9 + i); exp.rd = 5'd20;
            q.push_back(exp);
            tick();
            exp = q.pop_front(); got = sample(); checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_midop();
        e_t exp, got;
        #1;
        rst = 1'b0;
        #1;
        got = sample(); checks++;
        if (got !== '0) begin
            failures++;
            $display("FAIL async_reset got=%h exp=0", got);
        end
        #2;
        rst = 1'b1;
        q.delete();
        // addi x9,x5,0: x5 was cleared by the reset
        drive(32'h0002_8493, 32'd40, 32'd41, 1'b0, 5'd0, 32'd0, 1'b0);
        exp = '0; exp.regw = 1'b1; exp.alusrc = 1'b1; exp.pc = 32'd40; exp.pcp = 32'd41;
        exp.rs1 = 5'd5; exp.rd = 5'd9;
        q.push_back(exp);
        tick();
        exp = q.pop_front(); got = sample(); checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL reset_clears_rf got=%h exp=%h", got, exp);
        end
    endtask

    initial begin
        drive(32'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        test_reset();
        test_random_imm();
        test_addi();
        test_load_bypass();
        test_store();
        test_sub_flush();
        test_branch();
        test_alu_funct();
        test_x0();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
